// File: rtl/audio_clk_pkg.sv
// Shared types and constants for the I2S clock scheduler.
// The scheduler state encoding and the divide/frame limits live here.
package audio_clk_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } sched_state_e;

    localparam int MIN_DIV            = 1;
    localparam int FRAME_BITS_DEFAULT = 32;

endpackage

// File: rtl/i2s_clk_sched_if.sv
// Config handshake and clock/strobe outputs of the I2S clock scheduler.
// The scheduler is the slave; the controlling logic is the master.
interface i2s_clk_sched_if #(
    parameter int DIV_W = 8
);
    logic             enable;
    logic [DIV_W-1:0] cfg_div;
    logic             cfg_valid;
    logic             cfg_ready;
    logic             bclk;
    logic             lrclk;
    logic             bclk_rise;
    logic             bclk_fall;
    logic             frame_start;
    logic             busy;

    modport master (
        output enable, cfg_div, cfg_valid,
        input  cfg_ready, bclk, lrclk, bclk_rise, bclk_fall, frame_start, busy
    );

    modport slave (
        input  enable, cfg_div, cfg_valid,
        output cfg_ready, bclk, lrclk, bclk_rise, bclk_fall, frame_start, busy
    );
endinterface

// File: rtl/clk_half_cnt.sv
// Half-period counter for bclk: counts 0..div while enabled, wraps on terminal count.
// Disabling it parks the count at zero so the next run starts a clean half period.
module clk_half_cnt #(
    parameter int DIV_W = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic [DIV_W-1:0] div,
    output logic             tc
);
    logic [DIV_W-1:0] cnt;

    assign tc = en & (cnt == div);

    always_ff @(posedge clk) begin
        if (reset || !en) begin
            cnt <= '0;
        end else if (tc) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end
endmodule

// File: rtl/i2s_clk_sched.sv
// I2S bit/word clock scheduler: derives bclk, lrclk and edge strobes from clk_in,
// deferring divide changes made while running to the next frame boundary.
module i2s_clk_sched
    import audio_clk_pkg::*;
#(
    parameter int DIV_W       = 8,
    parameter int FRAME_BITS  = FRAME_BITS_DEFAULT,
    parameter int DEFAULT_DIV = 3
) (
    input  logic           clk_in,
    input  logic           reset,
    i2s_clk_sched_if.slave bus
);
    localparam int BIT_W = $clog2(2 * FRAME_BITS);

    localparam logic [1:0] S_IDLE  = IDLE;
    localparam logic [1:0] S_RUN   = RUN;
    localparam logic [1:0] S_DRAIN = DRAIN;

    logic [1:0]       state;
    logic [DIV_W-1:0] div_q;
    logic [DIV_W-1:0] pend_q;
    logic [DIV_W-1:0] cfg_eff;
    logic             pend_valid;
    logic [BIT_W-1:0] bit_cnt;
    logic [BIT_W-1:0] bit_cnt_next;
    logic             bclk_q;
    logic             lrclk_q;
    logic             rise_q;
    logic             fall_q;
    logic             fs_q;
    logic             running;
    logic             tc;
    logic             fall_ev;
    logic             boundary;
    logic             going_idle;
    logic             accept;

    assign running    = (state != S_IDLE);
    assign accept     = bus.cfg_valid & ~pend_valid;
    assign cfg_eff    = (bus.cfg_div < DIV_W'(MIN_DIV)) ? DIV_W'(MIN_DIV) : bus.cfg_div;
    assign fall_ev    = tc & bclk_q;
    assign boundary   = fall_ev & (bit_cnt == BIT_W'(2 * FRAME_BITS - 1));
    assign going_idle = boundary & (state == S_DRAIN) & ~bus.enable;

    always_comb begin
        bit_cnt_next = bit_cnt;
        if (boundary) begin
            bit_cnt_next = '0;
        end else if (fall_ev) begin
            bit_cnt_next = bit_cnt + 1'b1;
        end
    end

    clk_half_cnt #(.DIV_W(DIV_W)) u_half_cnt (
        .clk   (clk_in),
        .reset (reset),
        .en    (running),
        .div   (div_q),
        .tc    (tc)
    );

    // The frame-boundary edge swaps in any pending divide; an offer accepted
    // on the same edge that drops to IDLE is applied directly instead.
    always_ff @(posedge clk_in) begin
        if (reset) begin
            state      <= S_IDLE;
            div_q      <= DIV_W'(DEFAULT_DIV);
            pend_q     <= '0;
            pend_valid <= 1'b0;
            bit_cnt    <= '0;
            bclk_q     <= 1'b0;
            lrclk_q    <= 1'b0;
            rise_q     <= 1'b0;
            fall_q     <= 1'b0;
            fs_q       <= 1'b0;
        end else begin
            rise_q <= 1'b0;
            fall_q <= 1'b0;
            fs_q   <= 1'b0;
            if (!running) begin
                if (accept) begin
                    div_q <= cfg_eff;
                end
                if (bus.enable) begin
                    state <= S_RUN;
                    fs_q  <= 1'b1;
                end
            end else begin
                if (tc) begin
                    bclk_q <= ~bclk_q;
                    rise_q <= ~bclk_q;
                    fall_q <= bclk_q & ~going_idle;
                end
                bit_cnt <= bit_cnt_next;
                lrclk_q <= (bit_cnt_next >= BIT_W'(FRAME_BITS));
                if (accept) begin
                    pend_q     <= cfg_eff;
                    pend_valid <= 1'b1;
                end
                if (boundary && pend_valid) begin
                    div_q      <= pend_q;
                    pend_valid <= 1'b0;
                end
                if (going_idle) begin
                    state <= S_IDLE;
                    if (accept) begin
                        div_q      <= cfg_eff;
                        pend_valid <= 1'b0;
                    end
                end else begin
                    state <= bus.enable ? S_RUN : S_DRAIN;
                    fs_q  <= boundary;
                end
            end
        end
    end

    assign bus.bclk        = bclk_q;
    assign bus.lrclk       = lrclk_q;
    assign bus.bclk_rise   = rise_q;
    assign bus.bclk_fall   = fall_q;
    assign bus.frame_start = fs_q;
    assign bus.busy        = running;
    assign bus.cfg_ready   = ~pend_valid;
endmodule

// File: tb/tb_i2s_clk_sched.sv
// Self-checking bench for i2s_clk_sched: table vectors, directed corner sequences and
// random traffic against a frame-position reference model.
module tb_i2s_clk_sched;
    localparam int DIV_W   = 8;
    localparam int FB      = 32;
    localparam int DEF_DIV = 3;

    typedef struct packed {
        logic bclk;
        logic lrclk;
        logic rise;
        logic fall;
        logic fs;
        logic busy;
        logic ready;
    } outs_t;

    typedef struct {
        logic             rst;
        logic             en;
        logic             valid;
        logic [DIV_W-1:0] d;
        outs_t            exp;
    } vec_t;

    logic clk_in = 1'b0;
    logic reset;
    logic cur_en;
    int   checks = 0;
    int   errors = 0;

    i2s_clk_sched_if #(.DIV_W(DIV_W)) bus ();

    i2s_clk_sched #(
        .DIV_W       (DIV_W),
        .FRAME_BITS  (FB),
        .DEFAULT_DIV (DEF_DIV)
    ) dut (
        .clk_in (clk_in),
        .reset  (reset),
        .bus    (bus)
    );

    always #5 clk_in = ~clk_in;

    // Reference model: tracks the cycle position inside the current frame and derives
    // every output from it arithmetically (half period = div+1 cycles).
    int m_state;
    int m_pos;
    int m_div;
    int m_pend;
    bit m_pend_v;
    bit m_first;

    function automatic void modelReset();
        m_state  = 0;
        m_pos    = 0;
        m_div    = DEF_DIV;
        m_pend   = 0;
        m_pend_v = 1'b0;
        m_first  = 1'b1;
    endfunction

    function automatic void modelStep(input bit rst, input bit en, input bit valid, input int d);
        int clamped;
        bit accept;
        bit had_pend;
        if (rst) begin
            modelReset();
            return;
        end
        clamped = (d == 0) ? 1 : d;
        accept  = valid && !m_pend_v;
        if (m_state == 0) begin
            if (accept) m_div = clamped;
            if (en) begin
                m_state = 1;
                m_pos   = 0;
                m_first = 1'b1;
            end
            return;
        end
        had_pend = m_pend_v;
        if (accept) begin
            m_pend   = clamped;
            m_pend_v = 1'b1;
        end
        if (m_pos == 4 * FB * (m_div + 1) - 1) begin
            if (had_pend) begin
                m_div    = m_pend;
                m_pend_v = 1'b0;
            end
            if (m_state == 2 && !en) begin
                m_state = 0;
                if (accept) begin
                    m_div    = clamped;
                    m_pend_v = 1'b0;
                end
            end else begin
                m_state = en ? 1 : 2;
                m_pos   = 0;
                m_first = 1'b0;
            end
        end else begin
            m_pos   = m_pos + 1;
            m_state = en ? 1 : 2;
        end
    endfunction

    function automatic outs_t modelOut();
        outs_t o;
        int    half;
        int    h;
        int    ph;
        o       = '0;
        o.ready = !m_pend_v;
        if (m_state != 0) begin
            half   = m_div + 1;
            h      = m_pos / half;
            ph     = m_pos % half;
            o.bclk  = (h % 2) == 1;
            o.lrclk = (h / 2) >= FB;
            o.rise  = (ph == 0) && ((h % 2) == 1);
            o.fall  = (ph == 0) && ((h % 2) == 0) && (h > 0 || !m_first);
            o.fs    = (m_pos == 0);
            o.busy  = 1'b1;
        end
        return o;
    endfunction

    task automatic checkOutput(input string name, input outs_t exp);
        outs_t got;
        got = {bus.bclk, bus.lrclk, bus.bclk_rise, bus.bclk_fall, bus.frame_start, bus.busy, bus.cfg_ready};
        checks++;
        if (got !== exp) begin
            errors++;
            $display("[TB] FAIL %s at %0t: got %b, expected %b (bclk lrclk rise fall fs busy ready)", name, $time, got, exp);
        end
    endtask

    task automatic expectInt(input string name, input int got, input int exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, got, exp);
        end
    endtask

    task automatic applyStimulus(input logic rst, input logic en, input logic valid, input logic [DIV_W-1:0] d);
        @(negedge clk_in);
        reset         = rst;
        bus.enable    = en;
        bus.cfg_valid = valid;
        bus.cfg_div   = d;
        @(posedge clk_in);
        modelStep(rst, en, valid, int'(d));
        #1;
        checkOutput("model", modelOut());
    endtask

    task automatic runCycles(input int n);
        for (int i = 0; i < n; i++) applyStimulus(1'b0, cur_en, 1'b0, '0);
    endtask

    // Starting on a frame_start cycle, runs to the next frame_start and measures it.
    task automatic measureFrame(input int bound, output int gap, output int falls_to_lr,
                                output int rise_gap, output int min_phase);
        int   t;
        int   falls;
        int   first_rise;
        int   run_len;
        logic prev_bclk;
        t = 0; falls = 0; falls_to_lr = -1; first_rise = -1; rise_gap = -1;
        min_phase = 100000; gap = -1; run_len = 1; prev_bclk = bus.bclk;
        while (t < bound && gap < 0) begin
            applyStimulus(1'b0, cur_en, 1'b0, '0);
            t++;
            if (bus.bclk === prev_bclk) run_len++;
            else begin
                if (run_len < min_phase) min_phase = run_len;
                run_len   = 1;
                prev_bclk = bus.bclk;
            end
            if (bus.bclk_fall) falls++;
            if (bus.lrclk && falls_to_lr < 0) falls_to_lr = falls;
            if (bus.bclk_rise) begin
                if (first_rise < 0) first_rise = t;
                else if (rise_gap < 0) rise_gap = t - first_rise;
            end
            if (bus.frame_start) gap = t;
        end
    endtask

    task automatic waitFrameStart(input int bound, output int found, output int min_phase);
        int   t;
        int   run_len;
        bit   started;
        logic prev_bclk;
        t = 0; found = 0; min_phase = 100000; run_len = 0; started = 1'b0;
        prev_bclk = bus.bclk;
        while (t < bound && found == 0) begin
            applyStimulus(1'b0, cur_en, 1'b0, '0);
            t++;
            if (bus.bclk === prev_bclk) run_len++;
            else begin
                if (started && run_len < min_phase) min_phase = run_len;
                started   = 1'b1;
                run_len   = 1;
                prev_bclk = bus.bclk;
            end
            if (bus.frame_start) found = 1;
        end
    endtask

    task automatic monitorWindow(input int n, output int busy_low, output int max_phase);
        int   run_len;
        logic prev_bclk;
        busy_low = 0; max_phase = 0; run_len = 0; prev_bclk = bus.bclk;
        for (int i = 0; i < n; i++) begin
            applyStimulus(1'b0, cur_en, 1'b0, '0);
            if (!bus.busy) busy_low++;
            if (bus.bclk === prev_bclk) run_len++;
            else begin
                run_len   = 1;
                prev_bclk = bus.bclk;
            end
            if (run_len > max_phase) max_phase = run_len;
        end
    endtask

    vec_t vecs [12];

    initial begin
        int gap, f2lr, rgap, minph, found, cnt, fs_seen, busy_low, maxph;
        reset         = 1'b1;
        bus.enable    = 1'b0;
        bus.cfg_valid = 1'b0;
        bus.cfg_div   = '0;
        cur_en        = 1'b0;
        modelReset();

        vecs[0]  = '{1'b1, 1'b0, 1'b0, 8'd0, outs_t'(7'b0000001)};
        vecs[1]  = '{1'b0, 1'b0, 1'b1, 8'd3, outs_t'(7'b0000001)};
        vecs[2]  = '{1'b0, 1'b1, 1'b0, 8'd0, outs_t'(7'b0000111)};
        vecs[3]  = '{1'b0, 1'b1, 1'b0, 8'd0, outs_t'(7'b0000011)};
        vecs[4]  = '{1'b0, 1'b1, 1'b0, 8'd0, outs_t'(7'b0000011)};
        vecs[5]  = '{1'b0, 1'b1, 1'b0, 8'd0, outs_t'(7'b0000011)};
        vecs[6]  = '{1'b0, 1'b1, 1'b0, 8'd0, outs_t'(7'b1010011)};
        vecs[7]  = '{1'b0, 1'b1, 1'b0, 8'd0, outs_t'(7'b1000011)};
        vecs[8]  = '{1'b0, 1'b1, 1'b0, 8'd0, outs_t'(7'b1000011)};
        vecs[9]  = '{1'b0, 1'b1, 1'b0, 8'd0, outs_t'(7'b1000011)};
        vecs[10] = '{1'b0, 1'b1, 1'b0, 8'd0, outs_t'(7'b0001011)};
        vecs[11] = '{1'b0, 1'b1, 1'b0, 8'd0, outs_t'(7'b0000011)};

        for (int i = 0; i < 12; i++) begin
            applyStimulus(vecs[i].rst, vecs[i].en, vecs[i].valid, vecs[i].d);
            checkOutput($sformatf("vec%0d", i), vecs[i].exp);
        end

        // Default divide: 8-cycle bclk, 512-cycle frame, lrclk after 32 falls.
        cur_en = 1'b1;
        waitFrameStart(600, found, minph);
        expectInt("def_frame_found", found, 1);
        measureFrame(600, gap, f2lr, rgap, minph);
        expectInt("def_frame_gap", gap, 512);
        expectInt("def_lr_falls", f2lr, 32);
        expectInt("def_bclk_period", rgap, 8);
        expectInt("def_min_phase", minph, 4);

        // Divide programmed while idle takes effect on the first frame.
        applyStimulus(1'b1, 1'b0, 1'b0, '0);
        applyStimulus(1'b0, 1'b0, 1'b1, 8'd1);
        expectInt("idle_cfg_ready", int'(bus.cfg_ready), 1);
        applyStimulus(1'b0, 1'b1, 1'b0, '0);
        measureFrame(300, gap, f2lr, rgap, minph);
        expectInt("div1_frame_gap", gap, 256);
        expectInt("div1_bclk_period", rgap, 4);

        // Mid-frame change is held pending until the boundary.
        applyStimulus(1'b1, 1'b0, 1'b0, '0);
        applyStimulus(1'b0, 1'b1, 1'b0, '0);
        runCycles(100);
        applyStimulus(1'b0, 1'b1, 1'b1, 8'd7);
        expectInt("pend_ready_low", int'(bus.cfg_ready), 0);
        waitFrameStart(1000, found, minph);
        expectInt("pend_frame_found", found, 1);
        expectInt("pend_old_phase", minph, 4);
        expectInt("pend_ready_back", int'(bus.cfg_ready), 1);
        measureFrame(1100, gap, f2lr, rgap, minph);
        expectInt("div7_frame_gap", gap, 1024);
        expectInt("div7_bclk_period", rgap, 16);
        expectInt("div7_min_phase", minph, 8);
        expectInt("div7_lr_falls", f2lr, 32);

        // Drain: busy holds until the frame ends, no new frame starts.
        runCycles(50);
        cur_en = 1'b0;
        cnt = 0; fs_seen = 0;
        while (cnt < 1100 && bus.busy) begin
            applyStimulus(1'b0, cur_en, 1'b0, '0);
            cnt++;
            if (bus.frame_start) fs_seen++;
        end
        expectInt("drain_len", cnt, 1024 - 50);
        expectInt("drain_fs", fs_seen, 0);
        expectInt("drain_idle_clocks", int'({bus.bclk, bus.lrclk}), 0);

        // Re-raising enable during drain keeps bclk running without a gap.
        cur_en = 1'b1;
        runCycles(200);
        cur_en = 1'b0;
        monitorWindow(20, busy_low, maxph);
        expectInt("redrain_busy_low", busy_low, 0);
        cur_en = 1'b1;
        monitorWindow(1100, busy_low, maxph);
        expectInt("rerun_busy_low", busy_low, 0);
        expectInt("rerun_max_phase", maxph, 8);

        // Zero divide clamps to the minimum.
        applyStimulus(1'b1, 1'b0, 1'b0, '0);
        applyStimulus(1'b0, 1'b0, 1'b1, 8'd0);
        applyStimulus(1'b0, 1'b1, 1'b0, '0);
        measureFrame(300, gap, f2lr, rgap, minph);
        expectInt("clamp_bclk_period", rgap, 4);
        expectInt("clamp_frame_gap", gap, 256);

        // Reset discards a pending divide.
        applyStimulus(1'b1, 1'b0, 1'b0, '0);
        applyStimulus(1'b0, 1'b1, 1'b0, '0);
        runCycles(30);
        applyStimulus(1'b0, 1'b1, 1'b1, 8'd7);
        expectInt("rst_pend_ready_low", int'(bus.cfg_ready), 0);
        applyStimulus(1'b1, 1'b1, 1'b0, '0);
        checkOutput("reset_mid_outputs", outs_t'(7'b0000001));
        applyStimulus(1'b0, 1'b1, 1'b0, '0);
        measureFrame(600, gap, f2lr, rgap, minph);
        expectInt("rst_bclk_period", rgap, 8);
        expectInt("rst_frame_gap", gap, 512);

        // Random traffic against the model.
        cur_en = 1'b1;
        for (int i = 0; i < 4000; i++) begin
            logic             r;
            logic             v;
            logic [DIV_W-1:0] d;
            if ($urandom_range(0, 299) == 0) cur_en = ~cur_en;
            r = ($urandom_range(0, 1999) == 0);
            v = ($urandom_range(0, 31) == 0);
            d = DIV_W'($urandom_range(0, 3));
            applyStimulus(r, cur_en, v, d);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/i2s_clk_sched.md
Name: i2s_clk_sched

Overview:
- Controller for the audio clock path. Runs off the fast fabric clock and produces the I2S bit clock (bclk), the LR/word clock (lrclk), and single-cycle edge strobes for the codec serialiser/deserialiser.
- Divide ratio is programmable at run time via a valid/ready config port. New ratios take effect only on frame boundaries, so no runt bclk/lrclk pulses ever reach the codec.
- Sits between the clock divider output and the I2S TX/RX shift registers.

Parameters:
- DIV_W, 8: width of divide config.
- FRAME_BITS, 32: bclk periods per channel slot. A frame is 2*FRAME_BITS bits.
- DEFAULT_DIV, 3: divide value loaded at reset.

Ports:
- clk_in, in, 1: fabric clock; all logic on posedge.
- reset, in, 1: synchronous, active-high reset.
- enable, in, 1: request clock generation.
- cfg_div, in, DIV_W: half-period of bclk in clk_in cycles minus 1.
- cfg_valid, in, 1: config offer.
- cfg_ready, out, 1: config accept.
- bclk, out, 1: bit clock, registered.
- lrclk, out, 1: word clock (0 = left, 1 = right), registered.
- bclk_rise, out, 1: one-cycle strobe, same cycle bclk goes 0->1.
- bclk_fall, out, 1: one-cycle strobe, same cycle bclk goes 1->0.
- frame_start, out, 1: one-cycle strobe at start of each frame.
- busy, out, 1: state != IDLE.

Behaviour:
- Reset values:
  - bclk=0, lrclk=0, all strobes 0, busy=0, cfg_ready=1.
  - state=IDLE, div_q=DEFAULT_DIV, no pending config, cnt=0, bit_cnt=0.
- States: IDLE, RUN, DRAIN.
  - IDLE: outputs held low, counters at 0.
    - enable=1 -> RUN next cycle. frame_start pulses in that first RUN cycle.
  - RUN: half-period counter cnt counts 0..div_q. When cnt==div_q, bclk toggles and cnt wraps to 0.
    - bclk period = 2*(div_q+1) clk_in cycles.
    - enable=0 -> DRAIN.
  - DRAIN: identical to RUN, but at the frame boundary go to IDLE instead of starting a new frame.
    - enable=1 while in DRAIN -> back to RUN, no interruption.
- Bit and frame counting:
  - bit_cnt increments (mod 2*FRAME_BITS) on each falling bclk edge.
  - lrclk is registered as (bit_cnt_next >= FRAME_BITS), so it changes only coincident with bclk_fall.
  - Frame boundary = the bclk_fall where bit_cnt wraps 2*FRAME_BITS-1 -> 0. frame_start pulses on that same cycle (RUN only).
- Strobes: asserted in the same cycle as the registered bclk transition; they are never asserted in IDLE.
- Config handshake (transfer when cfg_valid & cfg_ready):
  - IDLE: div_q loads next cycle. cfg_ready stays 1.
  - RUN/DRAIN: value goes to a pending register and cfg_ready drops to 0. At the next frame boundary div_q <= pending, cnt <= 0, and cfg_ready returns to 1 the following cycle.
  - cfg_div==0 is clamped to 1 (minimum bclk period 4 clk_in cycles).
  - A frame boundary and a new transfer in the same cycle: the pending value applies; the new transfer is impossible because cfg_ready=0.
- DRAIN -> IDLE at a boundary: bclk=0, lrclk=0, cnt=0, bit_cnt=0. Any pending config is applied to div_q.
- Reset mid-operation: all state returns to reset values next cycle. Any pending config is discarded.

Decomposition:
- Shared package audio_clk_pkg holds:
  - state enum (IDLE/RUN/DRAIN)
  - MIN_DIV=1
  - FRAME_BITS default
- One sub-module is natural: clk_half_cnt, a loadable mod-(div+1) counter with a terminal-count output.
- FSM, bit counter and config logic stay in the top level.

Test Plan:
- Reset then enable=1 with DEFAULT_DIV=3:
  - frame_start in first RUN cycle.
  - first bclk_rise 4 cycles later.
  - bclk period 8.
  - lrclk rises after 32 bclk_falls.
  - frame_start repeats every 512 cycles.
- In IDLE, write cfg_div=1, then enable:
  - bclk period 4, frame 256 cycles.
  - cfg_ready stays 1.
- In RUN, write cfg_div=7 mid-frame:
  - cfg_ready=0 until the boundary.
  - period stays 8 until frame_start, then becomes 16.
  - no bclk high/low phase shorter than 4 cycles.
- Drop enable mid-frame:
  - busy stays 1 until the boundary, then bclk=lrclk=0 and busy=0.
  - Re-raise enable during DRAIN: no gap in bclk.
- cfg_div=0 written: bclk period 4 (clamped).
- Assert reset during RUN with a pending config:
  - next cycle all outputs are at reset values and cfg_ready=1.
  - after re-enable, period is 8 (pending discarded).
